// File: rtl/fir41_pkg.sv
// rtl/fir41_pkg.sv - shared state type, default sizes and counter helper for the FIR41 DA sequencer
package fir41_pkg;
  localparam int NBITS_DEF  = 13;
  localparam int LAT_DP_DEF = 2;
  localparam int TAPS_DEF   = 41;
  localparam int DIN_W      = 12;
  localparam int DOUT_W     = 29;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CALC,
    ST_DRAIN,
    ST_HOLD
  } seq_state_t;

  // A phase of n cycles is counted as n-1 down to 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction
endpackage

// File: rtl/fir41_seq_cnt.sv
// rtl/fir41_seq_cnt.sv - loadable down-counter with zero flag, shared by CALC and DRAIN
module fir41_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/fir41_da_seq.sv
// rtl/fir41_da_seq.sv - bit-serial DA FIR sequencer; FIR41_SEQ_BACK2BACK_EN lets HOLD accept the next sample directly
module fir41_da_seq
  import fir41_pkg::*;
#(
  parameter int NBITS  = NBITS_DEF,
  parameter int LAT_DP = LAT_DP_DEF,
  parameter int TAPS   = TAPS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             acc_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             primed,
  output logic             busy
);
  localparam int               FW       = $clog2(TAPS + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(TAPS);
  localparam logic [CNT_W-1:0] LAST_BIT = cnt_load(NBITS);
  localparam logic [CNT_W-1:0] DRAIN_LD = cnt_load(LAT_DP);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_ld_val;
  logic             cnt_zero, cnt_ld, cnt_en, accept;
  logic [FW-1:0]    fill;

  assign accept   = in_valid & in_ready;
  assign shift_en = accept;

  // The counter runs LAST_BIT..0 in CALC, so bit_idx is its complement.
  assign cnt_ld     = accept | ((state == ST_CALC) & cnt_zero);
  assign cnt_ld_val = accept ? LAST_BIT : DRAIN_LD;
  assign cnt_en     = (state == ST_CALC) | (state == ST_DRAIN);

  fir41_seq_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_INIT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  state_nxt = ST_IDLE;
      ST_IDLE:  if (accept) state_nxt = ST_CALC;
      ST_CALC:  if (cnt_zero) state_nxt = ST_DRAIN;
      ST_DRAIN: if (cnt_zero) state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nxt = accept ? ST_CALC : ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    acc_sub   = 1'b0;
    bit_idx   = '0;
    out_valid = 1'b0;
    busy      = (state != ST_INIT) && (state != ST_IDLE);
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_CALC: begin
        acc_en  = 1'b1;
        bit_idx = LAST_BIT - cnt;
        acc_clr = (cnt == LAST_BIT);
        acc_sub = cnt_zero;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
`ifdef FIR41_SEQ_BACK2BACK_EN
        in_ready  = out_ready;
`else
        in_ready  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fill <= '0;
    else if (accept && (fill != FILL_MAX))
      fill <= fill + 1'b1;
  end

  assign primed = (fill == FILL_MAX);
endmodule

// File: tb/tb_fir41_da_seq.sv
// tb/tb_fir41_da_seq.sv - randomized self-checking bench for fir41_da_seq against a timestamp model
module tb_fir41_da_seq;
  localparam int NB  = 13;
  localparam int LD  = 2;
  localparam int TP  = 41;
  localparam int LAT = 1 + NB + LD;
`ifdef FIR41_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam int PERIOD = B2B ? (NB + LD + 1) : (NB + LD + 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, shift_en, acc_clr, acc_en, acc_sub, out_valid, primed, busy;
  logic [3:0] bit_idx;

  always #5 clk = ~clk;

  fir41_da_seq #(.NBITS(NB), .LAT_DP(LD), .TAPS(TP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .bit_idx   (bit_idx),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .acc_sub   (acc_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .primed    (primed),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: m_age = cycles since the accepting cycle of the sample in flight, -1 when none.
  bit m_init  = 1'b1;
  int m_age   = -1;
  int m_fill  = 0;
  int cyc_n   = 0;
  int last_acc = -1;
  int acc_cnt = 0;
  int n_acc   = 0;
  bit ov_prev = 1'b0;
  bit pr_prev = 1'b0;
  bit cont    = 1'b0;

  task automatic cyc(input logic iv, input logic ordy, input logic rn);
    logic e_rdy, e_en, e_ov, e_acc, e_busy;
    int   e_bit;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    rst_n     = rn;
    #1;
    cyc_n++;
    e_rdy = 1'b0; e_en = 1'b0; e_ov = 1'b0; e_bit = 0; e_busy = 1'b0;
    if (rn && !m_init) begin
      e_busy = (m_age >= 0);
      if (m_age < 0)
        e_rdy = 1'b1;
      else if (m_age <= NB) begin
        e_en  = 1'b1;
        e_bit = m_age - 1;
      end else if (m_age > NB + LD) begin
        e_ov  = 1'b1;
        e_rdy = B2B ? ordy : 1'b0;
      end
    end
    e_acc = e_rdy & iv;
    check("in_ready",  in_ready,  e_rdy);
    check("shift_en",  shift_en,  e_acc);
    check("acc_en",    acc_en,    e_en);
    check("bit_idx",   bit_idx,   e_bit);
    check("acc_clr",   acc_clr,   e_en && (e_bit == 0));
    check("acc_sub",   acc_sub,   e_en && (e_bit == NB - 1));
    check("out_valid", out_valid, e_ov);
    check("busy",      busy,      e_busy);
    check("primed",    primed,    rn && (m_fill == TP));

    if (!rn) begin
      last_acc = -1; n_acc = 0; acc_cnt = 0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (last_acc >= 0) begin
          check("latency", cyc_n - last_acc, LAT);
          check("acc_cycles", acc_cnt, NB);
        end else
          check("ov_without_sample", out_valid, 1'b0);
      end
      if (primed && !pr_prev) check("primed_at", n_acc, TP);
      if (acc_en) acc_cnt++;
      if (shift_en) begin
        if (cont && last_acc >= 0) check("period", cyc_n - last_acc, PERIOD);
        last_acc = cyc_n;
        acc_cnt  = 0;
        n_acc++;
      end
    end

    if (!rn) begin
      m_init = 1'b1; m_age = -1; m_fill = 0;
    end else if (m_init)
      m_init = 1'b0;
    else if (e_acc) begin
      m_age = 1;
      if (m_fill < TP) m_fill++;
    end else if (e_ov && ordy)
      m_age = -1;
    else if (m_age >= 0)
      m_age++;
    ov_prev = out_valid;
    pr_prev = primed;
  endtask

  initial begin
    int n_ov, n_sh;
    repeat (3) cyc(1'b1, 1'b1, 1'b0);

    // Continuous traffic straight out of reset: latency, period, primed point.
    cont = 1'b1;
    repeat (50 * PERIOD + 4) cyc(1'b1, 1'b1, 1'b1);
    cont = 1'b0;
    check("primed_after_50", primed, 1'b1);

    // Stall a result in HOLD for 10 cycles with a sample waiting upstream.
    for (int i = 0; i < 4 * PERIOD && !(m_age > NB + LD); i++) cyc(1'b1, 1'b0, 1'b1);
    check("reached_hold", m_age > NB + LD, 1'b1);
    n_ov = 0; n_sh = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      n_ov += int'(out_valid);
      n_sh += int'(shift_en);
    end
    check("hold_ov_cycles", n_ov, 10);
    check("hold_shift_cnt", n_sh, 0);
    cyc(1'b0, 1'b1, 1'b1);

    // Reset in the middle of CALC at bit 5; nothing may emerge afterwards.
    for (int i = 0; i < 4 * PERIOD && m_age != 6; i++) cyc(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_bit", bit_idx, 5);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    n_ov = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      n_ov += int'(out_valid);
    end
    check("no_stale_ov", n_ov, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 599) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
